// File: rtl/vga_stream_pkg.sv
// Shared types and default 640x480 timing for the pixel stream source.
package vga_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_H_RES  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic int calc_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster counters with registered sync/de/frame-end decode.
// VGA_SRC_TEST_PATTERN_EN adds registered copies of the decoded position.
module vga_timing_counter
    import vga_stream_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_RES  = DEF_V_RES,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    localparam int H_TOTAL = calc_total(H_RES, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = calc_total(V_RES, V_FP, V_SYNC, V_BP),
    localparam int H_CNT_W = $clog2(H_TOTAL),
    localparam int V_CNT_W = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    output logic               frame_last,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
`ifdef VGA_SRC_TEST_PATTERN_EN
    output logic [H_CNT_W-1:0] h_pix,
    output logic [V_CNT_W-1:0] v_pix,
`endif
    output logic               frame_end
);

    localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_DE_END = H_CNT_W'(H_RES);
    localparam logic [H_CNT_W-1:0] HS_BEG   = H_CNT_W'(H_RES + H_FP);
    localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_DE_END = V_CNT_W'(V_RES);
    localparam logic [V_CNT_W-1:0] VS_BEG   = V_CNT_W'(V_RES + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_RES + V_FP + V_SYNC - 1);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               de_c;
    logic               hs_c;
    logic               vs_c;

    assign de_c       = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
    assign hs_c       = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    assign vs_c       = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Disabled counters sit at the origin with all decode outputs low,
    // so the first enabled cycle is always position (0,0).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            de        <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            frame_end <= 1'b0;
        end else if (!en) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            de        <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            de        <= de_c;
            hsync     <= hs_c;
            vsync     <= vs_c;
            frame_end <= frame_last;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + H_CNT_W'(1);
            end
        end
    end

`ifdef VGA_SRC_TEST_PATTERN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_pix <= '0;
            v_pix <= '0;
        end else begin
            h_pix <= h_cnt;
            v_pix <= v_cnt;
        end
    end
`endif

endmodule

// File: rtl/vga_stream_source.sv
// Frame-buffer reader and stream timing source for the filter chain.
// VGA_SRC_TEST_PATTERN_EN adds i_tp_sel, an x^y test pattern that bypasses the frame buffer.
module vga_stream_source
    import vga_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int H_RES  = DEF_H_RES,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_RES  = DEF_V_RES,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
`ifdef VGA_SRC_TEST_PATTERN_EN
    input  logic              i_tp_sel,
`endif
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]  i_rd_data,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_de,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_frame_done,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

    state_t state;
    logic   cnt_en;
    logic   frame_last;
    logic   de1;
    logic   hs1;
    logic   vs1;
    logic   fe1;

    assign cnt_en = (state != IDLE);
    assign o_busy = cnt_en;

`ifdef VGA_SRC_TEST_PATTERN_EN
    localparam int H_CNT_W = $clog2(calc_total(H_RES, H_FP, H_SYNC, H_BP));
    localparam int V_CNT_W = $clog2(calc_total(V_RES, V_FP, V_SYNC, V_BP));

    logic [H_CNT_W-1:0] h_pix1;
    logic [V_CNT_W-1:0] v_pix1;
    logic [H_CNT_W-1:0] h_pix2;
    logic [V_CNT_W-1:0] v_pix2;
    logic [WIDTH-1:0]   pattern;
`endif

    vga_timing_counter #(
        .H_RES  (H_RES),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_RES  (V_RES),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk        (clk),
        .rstn       (rstn),
        .en         (cnt_en),
        .frame_last (frame_last),
        .de         (de1),
        .hsync      (hs1),
        .vsync      (vs1),
`ifdef VGA_SRC_TEST_PATTERN_EN
        .h_pix      (h_pix1),
        .v_pix      (v_pix1),
`endif
        .frame_end  (fe1)
    );

    // A drop of i_en on the very last position ends the frame directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (i_en) state <= RUN;
                RUN:     if (!i_en) state <= frame_last ? IDLE : DRAIN;
                DRAIN: begin
                    if (i_en)
                        state <= RUN;
                    else if (frame_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address follows the read stage; it saturates on the last pixel and
    // is cleared in the cycle before the next frame's first read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            o_rd_addr <= '0;
        else if (fe1)
            o_rd_addr <= '0;
        else if (de1 && (o_rd_addr != ADDR_LAST))
            o_rd_addr <= o_rd_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_de         <= 1'b0;
            o_hsync      <= 1'b0;
            o_vsync      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_de         <= de1;
            o_hsync      <= hs1;
            o_vsync      <= vs1;
            o_frame_done <= fe1;
        end
    end

`ifdef VGA_SRC_TEST_PATTERN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_pix2 <= '0;
            v_pix2 <= '0;
        end else begin
            h_pix2 <= h_pix1;
            v_pix2 <= v_pix1;
        end
    end

    assign pattern = WIDTH'(h_pix2) ^ WIDTH'(v_pix2);
    assign o_rd_en = de1 & ~i_tp_sel;
    assign o_data  = o_de ? (i_tp_sel ? pattern : i_rd_data) : '0;
`else
    assign o_rd_en = de1;
    assign o_data  = o_de ? i_rd_data : '0;
`endif

endmodule
